dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-port, fixed-latency data memory between two requesters: the pipeline MEM stage and a DMA/debug port.
- Drives the memory command bus and returns read data to whichever requester owns the current access.
- Asserts the pipeline stall while a MEM-stage access is pending or in flight.
- Sits between the MEM pipeline slice and the data-memory macro, and replaces the direct MEM-stage connection to the memory.

Parameters:
LAT, 4, memory access latency in cycles (1..15); mem_rdata is valid in the last BUSY cycle
AW, 16, address width
DW, 16, data width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
pipe_re  input  1  MEM-stage read request; held until the cycle after the stall drops
pipe_we  input  1  MEM-stage write request; same hold rule as pipe_re
pipe_addr  input  AW  MEM-stage address
pipe_wdata  input  DW  MEM-stage write data
pipe_stall  output  1  combinational; freezes the pipeline
pipe_rdata  output  DW  registered read data for the pipeline
dma_req  input  1  DMA request; held high until dma_done
dma_we  input  1  DMA write (1) or read (0); sampled at grant
dma_addr  input  AW  DMA address; sampled at grant
dma_wdata  input  DW  DMA write data; sampled at grant
dma_done  output  1  one-cycle completion pulse to DMA
dma_rdata  output  DW  registered read data for DMA
mem_re  output  1  memory read enable (registered)
mem_we  output  1  memory write enable (registered)
mem_addr  output  AW  memory address (registered)
mem_wdata  output  DW  memory write data (registered)
mem_rdata  input  DW  memory read data

Behaviour:
- FSM states: IDLE, BUSY, DONE. Additional state: down-counter cnt (4 bits), owner bit (0 = pipe, 1 = DMA), last_owner bit.
- Reset (asynchronous; also when asserted mid-access):
  - state goes to IDLE and the access is aborted.
  - mem_re, mem_we, mem_addr, mem_wdata, pipe_rdata, dma_rdata, dma_done, cnt and owner all go to 0.
  - last_owner goes to 1, so the pipe wins the first tie.
  - pipe_stall is forced to 0 while rst is high.
- pipe_pending is (pipe_re | pipe_we).
- IDLE:
  - If only one requester is pending, grant it.
  - If both are pending, grant the one that is not last_owner (round-robin).
  - On grant: latch addr/wdata/op into the mem_* registers, set owner, set cnt = LAT-1, go to BUSY.
  - If pipe_re and pipe_we are both high, perform a write; pipe_rdata is 0 at completion.
- BUSY:
  - mem_re/mem_we are held for exactly LAT cycles.
  - cnt decrements each cycle.
  - When cnt == 0: capture mem_rdata into the owner's rdata register (read only), clear mem_re/mem_we, update last_owner = owner, go to DONE.
  - A write leaves the owner's rdata register unchanged, except the pipe re+we case above, where pipe_rdata is set to 0.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - No grant is made in DONE (one bubble cycle between accesses).
  - If owner is DMA, dma_done = 1 in this cycle only.
- pipe_stall = pipe_pending & ~(state == DONE & owner == pipe).
  - Pipe access timeline: request first seen at cycle 0 in IDLE, BUSY cycles 1..LAT, DONE at LAT+1.
  - Stall is high for cycles 0..LAT (LAT+1 cycles) and low at LAT+1, with pipe_rdata valid in that cycle.
  - A pipe access waiting behind a DMA access stalls for the DMA's remaining cycles plus its own LAT+1.
- DMA protocol:
  - If dma_req drops before dma_done, an access already granted still completes and pulses dma_done.
  - An ungranted request is simply withdrawn.
- Back-to-back pipe accesses are each serviced separately; a new request is first seen in the IDLE cycle after DONE.

Test Plan:
- LAT=4, pipe read of addr 0x0010 (memory holds 0xBEEF) at cycle 0 -> mem_re high cycles 1-4; pipe_stall high cycles 0-4, low at cycle 5; pipe_rdata = 0xBEEF at cycle 5.
- Pipe write 0x1234 to 0x0020, then pipe read of 0x0020 -> write stalls 5 cycles; the read is granted in the following IDLE cycle and returns 0x1234.
- dma_req and pipe_re both rise at cycle 0 after reset -> pipe granted first (pipe_rdata valid cycle 5); DMA granted at cycle 6, dma_done at cycle 11.
- DMA holds dma_req continuously while the pipe issues repeated reads -> grants strictly alternate DMA/pipe; neither requester waits more than one access.
- rst asserted at cycle 2 of a BUSY write -> mem_we immediately 0, pipe_stall 0, state IDLE; after release the held pipe request restarts with a full LAT-cycle access.
- pipe_re and pipe_we both high with LAT=1 -> write performed (mem_we 1 for one cycle), stall high for 2 cycles, pipe_rdata = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Function : Round-robin sharing of a fixed-latency single-port data memory
//            between the MEM pipeline stage and a DMA/debug port.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int LAT = 4,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_re,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_addr,
    input  logic [DW-1:0] pipe_wdata,
    output logic          pipe_stall,
    output logic [DW-1:0] pipe_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          owner_q;       // 0 = pipe, 1 = DMA
    logic          last_owner_q;
    logic          clr_q;         // pipe issued re+we together: result reads as zero
    logic          mem_re_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] pipe_rdata_q;
    logic [DW-1:0] dma_rdata_q;
    logic          dma_done_q;

    logic          w_pipe_pending;
    logic          w_grant_dma;

    assign w_pipe_pending = pipe_re | pipe_we;
    // DMA wins when it is alone, or on a tie when the pipe went last.
    assign w_grant_dma    = dma_req & (~w_pipe_pending | ~last_owner_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            clr_q        <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            pipe_rdata_q <= '0;
            dma_rdata_q  <= '0;
            dma_done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_pipe_pending | dma_req) begin
                        owner_q <= w_grant_dma;
                        cnt_q   <= CNT_INIT;
                        state_q <= BUSY;
                        if (w_grant_dma) begin
                            mem_re_q    <= ~dma_we;
                            mem_we_q    <= dma_we;
                            mem_addr_q  <= dma_addr;
                            mem_wdata_q <= dma_wdata;
                            clr_q       <= 1'b0;
                        end else begin
                            mem_re_q    <= ~pipe_we;
                            mem_we_q    <= pipe_we;
                            mem_addr_q  <= pipe_addr;
                            mem_wdata_q <= pipe_wdata;
                            clr_q       <= pipe_re & pipe_we;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        mem_re_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        last_owner_q <= owner_q;
                        dma_done_q   <= owner_q;
                        state_q      <= DONE;
                        if (mem_re_q) begin
                            if (owner_q) begin
                                dma_rdata_q <= mem_rdata;
                            end else begin
                                pipe_rdata_q <= mem_rdata;
                            end
                        end else if (!owner_q && clr_q) begin
                            pipe_rdata_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    dma_done_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The pipe is released only in the completion cycle of its own access.
    assign pipe_stall = ~rst & w_pipe_pending & ~((state_q == DONE) & ~owner_q);

    assign pipe_rdata = pipe_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign dma_done   = dma_done_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Function : Directed bench for dmem_arbiter with a timeline-based reference
//            model and hand-computed literal expectations.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_re, pipe_we;
    logic [15:0] pipe_addr, pipe_wdata;
    logic        pipe_stall;
    logic [15:0] pipe_rdata;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr, dma_wdata;
    logic        dma_done;
    logic [15:0] dma_rdata;
    logic        mem_re, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    // Second instance with LAT=1 for the single-cycle corner.
    logic        p1_re, p1_we;
    logic [15:0] p1_addr, p1_wdata;
    logic        p1_stall;
    logic [15:0] p1_rdata;
    logic        d1_done;
    logic [15:0] d1_rdata;
    logic        m1_re, m1_we;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] mdl_mem [256];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int n_re  = 0;
    int n_we  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.LAT(LAT), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .pipe_re(pipe_re), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.LAT(1), .AW(16), .DW(16)) dut1 (
        .clk(clk), .rst(rst),
        .pipe_re(p1_re), .pipe_we(p1_we), .pipe_addr(p1_addr), .pipe_wdata(p1_wdata),
        .pipe_stall(p1_stall), .pipe_rdata(p1_rdata),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0), .dma_wdata(16'h0),
        .dma_done(d1_done), .dma_rdata(d1_rdata),
        .mem_re(m1_re), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata)
    );

    function automatic logic [15:0] init_val(input int i);
        return (i == 16'h10) ? 16'hBEEF : (16'hA000 | 16'(i));
    endfunction

    // Memory macro models: contents reload on every reset.
    assign mem_rdata = mem_re ? mem0[mem_addr[7:0]] : 16'h0;
    assign m1_rdata  = m1_re  ? mem1[m1_addr[7:0]]  : 16'h0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= init_val(i);
                mem1[i] <= init_val(i);
            end
        end else begin
            if (mem_we) mem0[mem_addr[7:0]] <= mem_wdata;
            if (m1_we)  mem1[m1_addr[7:0]]  <= m1_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_re) n_re++;
        if (mem_we) n_we++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an access granted in cycle g occupies the memory in
    // cycles g+1..g+LAT, completes in g+LAT+1, and the port is free again
    // from g+LAT+2 on.
    // ------------------------------------------------------------------
    bit          acc_v;
    int          g;
    bit          a_own, a_we, a_clr;
    logic [15:0] a_addr, a_wdata;
    bit          m_last;
    logic [15:0] m_prd, m_drd;

    always @(negedge clk) begin
        bit in_mem, pp, own;
        if (rst) begin
            acc_v  = 1'b0;
            m_last = 1'b1;
            m_prd  = 16'h0;
            m_drd  = 16'h0;
            for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);
            chk("rst_stall", pipe_stall, 0);
            chk("rst_mem_re", mem_re, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_dma_done", dma_done, 0);
            chk("rst_pipe_rdata", pipe_rdata, 0);
            chk("rst_dma_rdata", dma_rdata, 0);
        end else begin
            if (acc_v && cyc == g + LAT + 1) begin
                m_last = a_own;
                if (a_we) begin
                    mdl_mem[a_addr[7:0]] = a_wdata;
                    if (!a_own && a_clr) m_prd = 16'h0;
                end else if (a_own) begin
                    m_drd = mdl_mem[a_addr[7:0]];
                end else begin
                    m_prd = mdl_mem[a_addr[7:0]];
                end
            end
            in_mem = acc_v && cyc >= g + 1 && cyc <= g + LAT;
            pp     = pipe_re | pipe_we;
            chk("mdl_mem_re", mem_re, in_mem && !a_we);
            chk("mdl_mem_we", mem_we, in_mem && a_we);
            if (in_mem) begin
                chk("mdl_mem_addr", mem_addr, a_addr);
                if (a_we) chk("mdl_mem_wdata", mem_wdata, a_wdata);
            end
            chk("mdl_dma_done", dma_done, acc_v && a_own && cyc == g + LAT + 1);
            chk("mdl_stall", pipe_stall, pp && !(acc_v && !a_own && cyc == g + LAT + 1));
            chk("mdl_pipe_rdata", pipe_rdata, m_prd);
            chk("mdl_dma_rdata", dma_rdata, m_drd);
            if ((!acc_v || cyc >= g + LAT + 2) && (pp || dma_req)) begin
                own   = (pp && dma_req) ? !m_last : dma_req;
                acc_v = 1'b1;
                g     = cyc;
                a_own = own;
                if (own) begin
                    a_we = dma_we;  a_addr = dma_addr;  a_wdata = dma_wdata;  a_clr = 1'b0;
                end else begin
                    a_we = pipe_we; a_addr = pipe_addr; a_wdata = pipe_wdata; a_clr = pipe_re & pipe_we;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Holds the request until the stall drops, then returns one cycle later.
    task automatic pipe_op(input logic re, input logic we, input logic [15:0] a,
                           input logic [15:0] d, output int dc, output logic [15:0] rd);
        bit ok = 1'b0;
        dc = -1;
        rd = 16'h0;
        pipe_re = re; pipe_we = we; pipe_addr = a; pipe_wdata = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!pipe_stall) begin
                ok = 1'b1; dc = cyc; rd = pipe_rdata;
                break;
            end
            tick();
        end
        chk("pipe_wait", ok, 1);
        tick();
    endtask

    task automatic dma_op(input logic we, input logic [15:0] a, input logic [15:0] d,
                          output int dc, output logic [15:0] rd);
        bit ok = 1'b0;
        dc = -1;
        rd = 16'h0;
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dma_done) begin
                ok = 1'b1; dc = cyc; rd = dma_rdata;
                break;
            end
            tick();
        end
        chk("dma_wait", ok, 1);
        tick();
        dma_req = 1'b0;
    endtask

    initial begin
        int          t0, d, d2;
        logic [15:0] r, r2;
        int          pd [3];
        int          dd [3];
        logic [15:0] dr0;

        rst = 1'b1;
        pipe_re = 0; pipe_we = 0; pipe_addr = 0; pipe_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        p1_re = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("init_pipe_rdata", pipe_rdata, 16'h0);
        chk("init_dma_done", dma_done, 0);
        chk("init_mem_we", mem_we, 0);
        tick();

        // Single pipe read
        t0 = cyc; n_re = 0;
        pipe_op(1, 0, 16'h0010, 16'h0, d, r);
        chk("t1_done_cycle", d - t0, 5);
        chk("t1_rdata", r, 16'hBEEF);
        chk("t1_re_cycles", n_re, 4);
        pipe_re = 0;

        // Write then read-back, back to back
        t0 = cyc;
        pipe_op(0, 1, 16'h0020, 16'h1234, d, r);
        chk("t2_wr_done", d - t0, 5);
        pipe_op(1, 0, 16'h0020, 16'h0, d, r);
        pipe_re = 0; pipe_we = 0;
        chk("t2_rd_done", d - t0, 11);
        chk("t2_rdata", r, 16'h1234);

        // DMA write observed by a later pipe read
        dma_op(1, 16'h0055, 16'h0C0C, d, r);
        pipe_op(1, 0, 16'h0055, 16'h0, d, r);
        pipe_re = 0;
        chk("t2b_rdata", r, 16'h0C0C);

        // Simultaneous requests after reset: pipe first, DMA next
        do_reset();
        t0 = cyc;
        fork
            begin
                pipe_op(1, 0, 16'h0060, 16'h0, d, r);
                pipe_re = 0;
            end
            dma_op(0, 16'h0050, 16'h0, d2, r2);
        join
        chk("t3_pipe_done", d - t0, 5);
        chk("t3_pipe_rdata", r, 16'hA060);
        chk("t3_dma_done", d2 - t0, 11);
        chk("t3_dma_rdata", r2, 16'hA050);

        // Continuous DMA against repeated pipe reads: strict alternation
        do_reset();
        t0 = cyc;
        dr0 = 16'h0;
        fork
            begin
                int          pdc;
                logic [15:0] prd;
                for (int k = 0; k < 3; k++) begin
                    pipe_op(1, 0, 16'h0011 + 16'(k), 16'h0, pdc, prd);
                    pd[k] = pdc - t0;
                end
                pipe_re = 0;
            end
            begin
                int          ddc;
                logic [15:0] drd;
                for (int k = 0; k < 3; k++) begin
                    dma_op(0, 16'h0021 + 16'(k), 16'h0, ddc, drd);
                    dd[k] = ddc - t0;
                    if (k == 0) dr0 = drd;
                end
            end
        join
        chk("t4_pipe0", pd[0], 5);
        chk("t4_dma0", dd[0], 11);
        chk("t4_pipe1", pd[1], 17);
        chk("t4_dma1", dd[1], 23);
        chk("t4_pipe2", pd[2], 29);
        chk("t4_dma2", dd[2], 35);
        chk("t4_dma_rdata", dr0, 16'hA021);

        // Reset in the second BUSY cycle of a pipe write
        do_reset();
        pipe_we = 1; pipe_addr = 16'h0030; pipe_wdata = 16'h5555;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_mem_we", mem_we, 0);
        chk("t5_rst_stall", pipe_stall, 0);
        tick();
        rst = 1'b0;
        n_we = 0;
        t0 = cyc;
        pipe_op(0, 1, 16'h0030, 16'h5555, d, r);
        pipe_we = 0;
        chk("t5_restart_done", d - t0, 5);
        chk("t5_we_cycles", n_we, 4);
        pipe_op(1, 0, 16'h0030, 16'h0, d, r);
        pipe_re = 0;
        chk("t5_readback", r, 16'h5555);

        // LAT=1 instance: read, then re+we collision
        do_reset();
        p1_re = 1; p1_addr = 16'h0070;
        @(negedge clk);
        chk("t6_rd_stall0", p1_stall, 1);
        tick();
        @(negedge clk);
        chk("t6_rd_mem_re", m1_re, 1);
        chk("t6_rd_stall1", p1_stall, 1);
        tick();
        @(negedge clk);
        chk("t6_rd_stall2", p1_stall, 0);
        chk("t6_rd_rdata", p1_rdata, 16'hA070);
        tick();
        p1_re = 1; p1_we = 1; p1_addr = 16'h0040; p1_wdata = 16'h7777;
        @(negedge clk);
        chk("t6_rw_stall0", p1_stall, 1);
        chk("t6_rw_we0", m1_we, 0);
        tick();
        @(negedge clk);
        chk("t6_rw_we1", m1_we, 1);
        chk("t6_rw_re1", m1_re, 0);
        chk("t6_rw_stall1", p1_stall, 1);
        tick();
        @(negedge clk);
        chk("t6_rw_stall2", p1_stall, 0);
        chk("t6_rw_we2", m1_we, 0);
        chk("t6_rw_rdata", p1_rdata, 16'h0);
        tick();
        p1_re = 0; p1_we = 0;
        tick();
        chk("t6_mem_written", mem1[8'h40], 16'h7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
